muldiv_seq: RTL

Sequencer for the RV32M multiply/divide unit. It sits beside the integer ALU in the execute stage and accepts one M-extension operation at a time from decode. Multiplies run on a pipelined multiplier; divides and remainders run on an iterative restoring divider, and the architectural divide-by-zero and overflow cases resolve early. While an operation is in flight the block raises `busy` to stall the core, then pulses `done` with the 32-bit result.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_seq_if.sv | 14 +
 rtl/div_restoring.sv | 38 +++
 rtl/muldiv_seq.sv | 136 +++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Issue/completion bundle between decode/execute and the mul/div sequencer.
interface muldiv_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic            kill;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, kill, funct3, rs1, rs2, input busy, done, result);
  modport slave  (input start, kill, funct3, rs1, rs2, output busy, done, result);
endinterface

// File: rtl/div_restoring.sv
// Unsigned restoring divider datapath: one quotient bit per step, MSB first.
module div_restoring #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN-1:0] r_rem, r_quo, r_dvs;
  logic [XLEN:0]   w_shift, w_diff;

  // Dividend bits shift out of the quotient register into the partial remainder.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (step) begin
      r_rem <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
    end
  end

  assign rem_out = r_rem;
  assign quo_out = r_quo;

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: pipelined multiply, iterative divide,
// early resolution of divide-by-zero and signed overflow.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input logic        clk,
  input logic        rst_n,
  muldiv_seq_if.slave bus
);

  localparam int CNT_MAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);

  state_e            r_state;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_f3;
  logic [XLEN:0]     r_a, r_b;
  logic              r_neg_q, r_neg_r;
  logic              r_busy, r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_issue, w_sgn_div, w_dz, w_ovf, w_s1, w_s2, w_a_sgn, w_b_sgn;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_spec_res, w_rem, w_quo, w_div_res, w_mul_res;
  logic [2*XLEN-1:0] w_ax, w_bx, w_prod;

  assign w_issue   = bus.start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_sgn_div = !bus.funct3[0];
  assign w_dz      = (bus.rs2 == '0);
  assign w_ovf     = w_sgn_div && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
  assign w_s1      = w_sgn_div & bus.rs1[XLEN-1];
  assign w_s2      = w_sgn_div & bus.rs2[XLEN-1];
  assign w_mag1    = w_s1 ? -bus.rs1 : bus.rs1;
  assign w_mag2    = w_s2 ? -bus.rs2 : bus.rs2;
  assign w_spec_res = bus.funct3[1] ? (w_dz ? bus.rs1 : '0)
                                    : (w_dz ? '1 : {1'b1, {(XLEN-1){1'b0}}});

  // MULHU is the only op with an unsigned rs1; only MUL/MULH sign-extend rs2.
  assign w_a_sgn = (bus.funct3[1:0] != 2'b11);
  assign w_b_sgn = !bus.funct3[1];

  // Low 2*XLEN bits of the sign-extended product are exact for every op.
  assign w_ax      = {{(XLEN-1){r_a[XLEN]}}, r_a};
  assign w_bx      = {{(XLEN-1){r_b[XLEN]}}, r_b};
  assign w_prod    = w_ax * w_bx;
  assign w_mul_res = (r_f3 == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  div_restoring #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_issue && !bus.kill && is_div(bus.funct3) && !w_dz && !w_ovf),
    .step       (r_state == S_DIV && !bus.kill),
    .i_dividend (w_mag1),
    .i_divisor  (w_mag2),
    .rem_out    (w_rem),
    .quo_out    (w_quo)
  );

  assign w_div_res = r_f3[1] ? (r_neg_r ? -w_rem : w_rem)
                             : (r_neg_q ? -w_quo : w_quo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (bus.kill) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_issue) begin
            r_f3    <= bus.funct3[1:0];
            r_a     <= {w_a_sgn & bus.rs1[XLEN-1], bus.rs1};
            r_b     <= {w_b_sgn & bus.rs2[XLEN-1], bus.rs2};
            r_neg_q <= w_s1 ^ w_s2;
            r_neg_r <= w_s1;
            if (!is_div(bus.funct3)) begin
              r_state <= S_MUL;
              r_cnt   <= CW'(MUL_CYCLES - 1);
              r_busy  <= 1'b1;
            end else if (w_dz || w_ovf) begin
              r_state  <= S_DONE;
              r_result <= w_spec_res;
              r_done   <= 1'b1;
            end else begin
              r_state <= S_DIV;
              r_cnt   <= CW'(XLEN - 1);
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            r_state  <= S_DONE;
            r_result <= w_mul_res;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DIV: begin
          if (r_cnt == '0) r_state <= S_FIX;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_state  <= S_DONE;
          r_result <= w_div_res;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule
